// File: rtl/selector_overlay.sv
// Selector overlay: a blinking ring sprite drawn over one cell of a grid.
// Moves take effect at frame boundaries; the pixel path is a 2-cycle pipeline.
module selector_overlay #(
  parameter int unsigned ORIGIN_X     = 0,
  parameter int unsigned ORIGIN_Y     = 0,
  parameter int unsigned CELL_W       = 66,
  parameter int unsigned CELL_H       = 66,
  parameter int unsigned GRID_COLS    = 8,
  parameter int unsigned GRID_ROWS    = 8,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        sel_load,
  input  logic [2:0]  sel_col,
  input  logic [2:0]  sel_row,
  input  logic        blink_en,
  output logic [6:0]  rom_addr,
  input  logic [58:0] rom_data,
  output logic        pix_on,
  output logic        pix_out_valid
);
  localparam int unsigned POS_W   = 3;
  localparam int unsigned COORD_W = 12;
  localparam int unsigned SPR_W   = 59;
  localparam int unsigned SPR_H   = 66;
  localparam int unsigned CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [5:0]  SPR_MSB = 6'(SPR_W - 1);

  logic [POS_W-1:0] act_col, act_row, pend_col, pend_row;
  logic             pend_vld;
  logic             sel_ok_c;

  assign sel_ok_c = sel_load && (32'(sel_col) < GRID_COLS) && (32'(sel_row) < GRID_ROWS);

  // Pending/active position; active only changes on a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_col  <= '0;
      act_row  <= '0;
      pend_col <= '0;
      pend_row <= '0;
      pend_vld <= 1'b0;
    end else if (frame_start) begin
      if (sel_ok_c) begin
        act_col  <= sel_col;
        act_row  <= sel_row;
        pend_vld <= 1'b0;
      end else if (pend_vld) begin
        act_col  <= pend_col;
        act_row  <= pend_row;
        pend_vld <= 1'b0;
      end
    end else if (sel_ok_c) begin
      pend_col <= sel_col;
      pend_row <= sel_row;
      pend_vld <= 1'b1;
    end
  end

  logic [COORD_W-1:0] x0, y0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0 <= COORD_W'(ORIGIN_X);
      y0 <= COORD_W'(ORIGIN_Y);
    end else begin
      x0 <= COORD_W'(ORIGIN_X) + COORD_W'(act_col) * COORD_W'(CELL_W);
      y0 <= COORD_W'(ORIGIN_Y) + COORD_W'(act_row) * COORD_W'(CELL_H);
    end
  end

  logic [COORD_W-1:0] dx_c, dy_c;
  logic               in_box_c;

  assign dx_c     = {1'b0, pix_x} - x0;
  assign dy_c     = {1'b0, pix_y} - y0;
  assign in_box_c = ({1'b0, pix_x} >= x0) && (dx_c < COORD_W'(SPR_W)) &&
                    ({1'b0, pix_y} >= y0) && (dy_c < COORD_W'(SPR_H));

  logic       valid1, in_box1;
  logic [5:0] dx1;

  // Stage 1: box test and sprite row fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1   <= 1'b0;
      in_box1  <= 1'b0;
      dx1      <= '0;
      rom_addr <= '0;
    end else begin
      valid1 <= pix_valid;
      if (pix_valid) begin
        in_box1 <= in_box_c;
        dx1     <= dx_c[5:0];
        if (in_box_c) rom_addr <= dy_c[6:0];
      end
    end
  end

  logic [CNT_W-1:0] blink_cnt;
  logic             vis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      vis       <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      vis       <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        vis       <= ~vis;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  logic sprite_bit_c;

  assign sprite_bit_c = rom_data[SPR_MSB - dx1];

  // Stage 2: sprite bit gated by visibility at the time the pixel leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_on        <= 1'b0;
      pix_out_valid <= 1'b0;
    end else begin
      pix_on        <= valid1 && in_box1 && vis && sprite_bit_c;
      pix_out_valid <= valid1;
    end
  end
endmodule
